hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage core; drives the F/D, D/E, E/M, M/W register controls.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_stall_ctrl_if.sv | 46 ++++
 rtl/md_seq.sv | 68 ++++++
 rtl/hazard_stall_ctrl.sv | 64 ++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared widths, MDU op/FSM encodings and the per-operand hazard compare
package hazard_pkg;

  localparam int TUSE_W = 2;
  localparam int TNEW_W = 2;
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A producer blocks a consumer when it targets the same non-zero register
  // and its result arrives later than the consumer needs it.
  function automatic logic reg_hazard(
    input logic [4:0]        src,
    input logic [TUSE_W-1:0] t_use,
    input logic              we,
    input logic [4:0]        dst,
    input logic [TNEW_W-1:0] t_new
  );
    return (src != 5'd0) && we && (dst == src) && (t_new > t_use);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for the hazard/stall controller
interface hazard_stall_ctrl_if;
  import hazard_pkg::*;

  logic [4:0]        D_rs_addr;
  logic [4:0]        D_rt_addr;
  logic [TUSE_W-1:0] D_T_use_rs;
  logic [TUSE_W-1:0] D_T_use_rt;
  logic              D_is_md;
  logic [4:0]        E_WriteRegAddr;
  logic              E_RegWrite;
  logic [TNEW_W-1:0] E_T_new;
  logic [4:0]        M_WriteRegAddr;
  logic              M_RegWrite;
  logic [TNEW_W-1:0] M_T_new;
  logic              E_md_start;
  logic              E_md_op;

  logic              HCU_EN_PC;
  logic              HCU_EN_FD;
  logic              HCU_CLR_DE;
  logic              HCU_EN_EM;
  logic              HCU_EN_MW;
  logic              md_busy;
  logic              md_done;
  logic [31:0]       stall_cnt;

  modport master (
    output D_rs_addr, D_rt_addr, D_T_use_rs, D_T_use_rt, D_is_md,
           E_WriteRegAddr, E_RegWrite, E_T_new,
           M_WriteRegAddr, M_RegWrite, M_T_new,
           E_md_start, E_md_op,
    input  HCU_EN_PC, HCU_EN_FD, HCU_CLR_DE, HCU_EN_EM, HCU_EN_MW,
           md_busy, md_done, stall_cnt
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_T_use_rs, D_T_use_rt, D_is_md,
           E_WriteRegAddr, E_RegWrite, E_T_new,
           M_WriteRegAddr, M_RegWrite, M_T_new,
           E_md_start, E_md_op,
    output HCU_EN_PC, HCU_EN_FD, HCU_CLR_DE, HCU_EN_EM, HCU_EN_MW,
           md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/md_seq.sv
// rtl/md_seq.sv - mult/div unit sequencer: IDLE/BUSY FSM with a down-counting busy counter
module md_seq
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  output logic busy,
  output logic done
);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] load_val;

  assign load_val = (op == MD_OP_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Starts mid-operation are dropped; only the final busy cycle may chain a new op.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nx = MD_BUSY;
          cnt_nx   = load_val;
        end
      end
      MD_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          if (start) begin
            cnt_nx = load_val;
          end else begin
            state_nx = MD_IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = MD_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
    done = (state == MD_BUSY) && (cnt == CNT_W'(1));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/MDU hazard detection and pipeline register control; HCU_STALL_CNT_EN adds a stall counter
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic                 clk,
  input logic                 reset,
  hazard_stall_ctrl_if.slave  bus
);

  logic hz_rs, hz_rt, hz_md, stall;
  logic md_busy_w, md_done_w;

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (bus.E_md_start),
    .op    (bus.E_md_op),
    .busy  (md_busy_w),
    .done  (md_done_w)
  );

  always_comb begin
    hz_rs = reg_hazard(bus.D_rs_addr, bus.D_T_use_rs, bus.E_RegWrite, bus.E_WriteRegAddr, bus.E_T_new)
          | reg_hazard(bus.D_rs_addr, bus.D_T_use_rs, bus.M_RegWrite, bus.M_WriteRegAddr, bus.M_T_new);
    hz_rt = reg_hazard(bus.D_rt_addr, bus.D_T_use_rt, bus.E_RegWrite, bus.E_WriteRegAddr, bus.E_T_new)
          | reg_hazard(bus.D_rt_addr, bus.D_T_use_rt, bus.M_RegWrite, bus.M_WriteRegAddr, bus.M_T_new);
    // A start in E is counted as busy so an MDU user in D cannot slip past it.
    hz_md = bus.D_is_md & (md_busy_w | bus.E_md_start);
    stall = hz_rs | hz_rt | hz_md;
  end

  assign bus.HCU_EN_PC  = ~stall;
  assign bus.HCU_EN_FD  = ~stall;
  assign bus.HCU_CLR_DE = stall;
  assign bus.HCU_EN_EM  = 1'b1;
  assign bus.HCU_EN_MW  = 1'b1;
  assign bus.md_busy    = md_busy_w;
  assign bus.md_done    = md_done_w;

`ifdef HCU_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'h1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed and randomized checks of hazard_stall_ctrl against a behavioural model
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int          md_rem = 0;
  int unsigned stall_total = 0;
  logic        obs_busy, obs_done;
  int          busy_seen, done_at, stall_seen;

  hazard_stall_ctrl_if hif ();

  hazard_stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_stall();
    int src[2];
    int tuse[2];
    bit h = 1'b0;
    src[0] = int'(hif.D_rs_addr);  tuse[0] = int'(hif.D_T_use_rs);
    src[1] = int'(hif.D_rt_addr);  tuse[1] = int'(hif.D_T_use_rt);
    for (int i = 0; i < 2; i++) begin
      if (src[i] != 0) begin
        if (hif.E_RegWrite && int'(hif.E_WriteRegAddr) == src[i] && int'(hif.E_T_new) > tuse[i]) h = 1'b1;
        if (hif.M_RegWrite && int'(hif.M_WriteRegAddr) == src[i] && int'(hif.M_T_new) > tuse[i]) h = 1'b1;
      end
    end
    if (hif.D_is_md && (md_rem > 0 || hif.E_md_start)) h = 1'b1;
    return h;
  endfunction

  task automatic idle_inputs();
    hif.D_rs_addr = 0;  hif.D_rt_addr = 0;
    hif.D_T_use_rs = 2'd3;  hif.D_T_use_rt = 2'd3;  hif.D_is_md = 0;
    hif.E_WriteRegAddr = 0; hif.E_RegWrite = 0; hif.E_T_new = 0;
    hif.M_WriteRegAddr = 0; hif.M_RegWrite = 0; hif.M_T_new = 0;
    hif.E_md_start = 0; hif.E_md_op = 0;
  endtask

  // Called just after a falling edge with inputs applied; ends at the next falling edge.
  task automatic step();
    bit s;
    #1;
    s = exp_stall();
    check("en_pc",  {31'b0, hif.HCU_EN_PC},  {31'b0, ~s});
    check("en_fd",  {31'b0, hif.HCU_EN_FD},  {31'b0, ~s});
    check("clr_de", {31'b0, hif.HCU_CLR_DE}, {31'b0, s});
    check("en_em",  {31'b0, hif.HCU_EN_EM},  32'd1);
    check("en_mw",  {31'b0, hif.HCU_EN_MW},  32'd1);
    check("md_busy", {31'b0, hif.md_busy}, {31'b0, md_rem > 0});
    check("md_done", {31'b0, hif.md_done}, {31'b0, md_rem == 1});
`ifdef HCU_STALL_CNT_EN
    check("stall_cnt", hif.stall_cnt, stall_total);
`else
    check("stall_cnt", hif.stall_cnt, 32'd0);
`endif
    obs_busy = hif.md_busy;
    obs_done = hif.md_done;
    @(posedge clk);
    if (s) stall_total = stall_total + 1;
    if (md_rem == 0 || md_rem == 1) md_rem = hif.E_md_start ? (hif.E_md_op ? DIV_N : MULT_N) : 0;
    else md_rem = md_rem - 1;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    md_rem = 0;
    stall_total = 0;
    check("rst_busy", {31'b0, hif.md_busy}, 32'd0);
    check("rst_done", {31'b0, hif.md_done}, 32'd0);
    check("rst_cnt",  hif.stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset_en_pc",  {31'b0, hif.HCU_EN_PC},  32'd1);
    check("reset_clr_de", {31'b0, hif.HCU_CLR_DE}, 32'd0);
    check("reset_busy",   {31'b0, hif.md_busy},    32'd0);
    check("reset_done",   {31'b0, hif.md_done},    32'd0);
    check("reset_cnt",    hif.stall_cnt,           32'd0);
    @(negedge clk);
    reset = 1'b1;

    // lw $1 in E followed by add $2,$1,$3 in D
    idle_inputs();
    hif.E_RegWrite = 1; hif.E_WriteRegAddr = 5'd1; hif.E_T_new = 2'd2;
    hif.D_rs_addr = 5'd1; hif.D_T_use_rs = 2'd1; hif.D_rt_addr = 5'd3; hif.D_T_use_rt = 2'd1;
    #1;
    check("lw_use_stall", {31'b0, hif.HCU_EN_PC}, 32'd0);
    step();
    hif.E_RegWrite = 0; hif.E_WriteRegAddr = 0; hif.E_T_new = 0;
    hif.M_RegWrite = 1; hif.M_WriteRegAddr = 5'd1; hif.M_T_new = 2'd1;
    #1;
    check("lw_use_release", {31'b0, hif.HCU_EN_PC}, 32'd1);
    step();

    // writes to $0 never create a dependence
    idle_inputs();
    hif.E_RegWrite = 1; hif.E_WriteRegAddr = 5'd0; hif.E_T_new = 2'd2;
    hif.D_rs_addr = 5'd0; hif.D_T_use_rs = 2'd0;
    #1;
    check("r0_no_stall", {31'b0, hif.HCU_CLR_DE}, 32'd0);
    step();

    // div with mflo waiting in D
    idle_inputs();
    busy_seen = 0; done_at = 0; stall_seen = 0;
    hif.E_md_start = 1; hif.E_md_op = 1; hif.D_is_md = 1;
    #1;
    if (hif.HCU_CLR_DE) stall_seen++;
    step();
    hif.E_md_start = 0;
    for (int i = 1; i <= 12; i++) begin
      #1;
      if (hif.HCU_CLR_DE) stall_seen++;
      step();
      if (obs_busy) busy_seen++;
      if (obs_done) done_at = i;
    end
    check("div_busy_len", busy_seen, DIV_N);
    check("div_done_at",  done_at,   DIV_N);
    check("div_stall_len", stall_seen, DIV_N + 1);

    // mult with no MDU user, chained by a second mult on the done cycle
    idle_inputs();
    busy_seen = 0; stall_seen = 0;
    hif.E_md_start = 1; hif.E_md_op = 0;
    step();
    hif.E_md_start = 0;
    for (int i = 0; i < 12; i++) begin
      hif.E_md_start = (md_rem == 1 && busy_seen < MULT_N);
      #1;
      if (hif.HCU_CLR_DE) stall_seen++;
      step();
      if (obs_busy) busy_seen++;
    end
    hif.E_md_start = 0;
    check("mult_chain_busy", busy_seen, 2 * MULT_N);
    check("mult_no_stall",   stall_seen, 0);

    // reset pulled mid-div at counter==3
    idle_inputs();
    hif.E_md_start = 1; hif.E_md_op = 1;
    step();
    hif.E_md_start = 0;
    for (int i = 0; i < 20 && md_rem != 3; i++) step();
    pulse_reset();
    hif.D_is_md = 1;
    step();
    step();

    // seven forced stall cycles from a fresh reset
    idle_inputs();
    pulse_reset();
    hif.E_RegWrite = 1; hif.E_WriteRegAddr = 5'd4; hif.E_T_new = 2'd2;
    hif.D_rt_addr = 5'd4; hif.D_T_use_rt = 2'd0;
    repeat (7) step();
    idle_inputs();
    #1;
`ifdef HCU_STALL_CNT_EN
    check("stall_cnt_7", hif.stall_cnt, 32'd7);
`else
    check("stall_cnt_off", hif.stall_cnt, 32'd0);
`endif
    step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      hif.D_rs_addr      = 5'($urandom_range(0, 3));
      hif.D_rt_addr      = 5'($urandom_range(0, 3));
      hif.D_T_use_rs     = 2'($urandom_range(0, 3));
      hif.D_T_use_rt     = 2'($urandom_range(0, 3));
      hif.D_is_md        = ($urandom_range(0, 3) == 0);
      hif.E_WriteRegAddr = 5'($urandom_range(0, 3));
      hif.E_RegWrite     = 1'($urandom_range(0, 1));
      hif.E_T_new        = 2'($urandom_range(0, 2));
      hif.M_WriteRegAddr = 5'($urandom_range(0, 3));
      hif.M_RegWrite     = 1'($urandom_range(0, 1));
      hif.M_T_new        = 2'($urandom_range(0, 2));
      hif.E_md_start     = ($urandom_range(0, 7) == 0);
      hif.E_md_op        = 1'($urandom_range(0, 1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
